// File: rtl/reg_pipe_pkg.sv
// -----------------------------------------------------------------------------
// reg_pipe_pkg
// Shared constants, types and helpers for the reg_pipe handshaked register
// pipeline.
//   REG_PIPE_DEPTH_MAX : largest supported stage count
//   REG_PIPE_WIDTH_MAX : widest data word carried by pipe_stage_t
//   pipe_stage_t       : {valid, data} snapshot of one stage, for benches
//   clog2_p1(n)        : bits needed to hold the values 0..n (occupancy width)
// -----------------------------------------------------------------------------
package reg_pipe_pkg;

  localparam int REG_PIPE_DEPTH_MAX = 64;
  localparam int REG_PIPE_WIDTH_MAX = 64;

  typedef struct packed {
    logic                          valid;
    logic [REG_PIPE_WIDTH_MAX-1:0] data;
  } pipe_stage_t;

  // Smallest w with 2**w > n, i.e. the width of a counter reaching n.
  // The loop stops at 30 so the shift never reaches the sign bit.
  function automatic int clog2_p1(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < (n + 32'sd1)) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage : reg_pipe_pkg

// File: rtl/reg_pipe_stage.sv
// -----------------------------------------------------------------------------
// reg_pipe_stage
// One WIDTH-bit stage of reg_pipe: a valid flag, a data register and the
// stage's contribution to the ready chain.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset (clears valid and data)
//   flush      : synchronous clear of the valid flag, data untouched
//   load       : capture d_in this cycle (already gated against flush)
//   d_in       : data offered by the previous stage or the pipe input
//   down_ready : next stage (or downstream) can take this stage's beat
//   v          : stage holds a beat
//   d          : stage data (don't-care while v is low)
//   ready      : stage can accept a beat this cycle
// -----------------------------------------------------------------------------
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             down_ready,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             ready
);

  logic             v_r;
  logic [WIDTH-1:0] d_r;

  // A stage is free when empty, or when its current beat moves on this cycle.
  assign ready = !v_r || down_ready;
  assign v     = v_r;
  assign d     = d_r;

  // Valid flag: a load wins over the departure of the previous beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r <= 1'b0;
    end else if (flush) begin
      v_r <= 1'b0;
    end else if (load) begin
      v_r <= 1'b1;
    end else if (v_r && down_ready) begin
      v_r <= 1'b0;
    end else begin
      v_r <= v_r;
    end
  end

  // Data register: changes only on a load, so an emptied stage keeps stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_r <= {WIDTH{1'b0}};
    end else if (load) begin
      d_r <= d_in;
    end else begin
      d_r <= d_r;
    end
  end

endmodule : reg_pipe_stage

// File: rtl/reg_pipe.sv
// -----------------------------------------------------------------------------
// reg_pipe
// Valid/ready register pipeline of DEPTH stages carrying WIDTH-bit beats.
// Empty stages are filled while the output is stalled (bubble collapsing), so
// the pipe only back-pressures when every stage is full and out_ready is low.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   flush     : synchronous clear of all stages (data untouched)
//   in_valid  : upstream beat present
//   in_data   : upstream data
//   in_ready  : pipe accepts a beat this cycle (combinational from out_ready)
//   out_valid : last stage holds a beat
//   out_data  : last stage data
//   out_ready : downstream accepts a beat this cycle
//   occ       : number of valid stages (registered)
// Build option: define REG_PIPE_OCC_EN to implement occ; otherwise occ is
// tied to zero.
// -----------------------------------------------------------------------------
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OCCW  = clog2_p1(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic            out_ready,
  output logic [OCCW-1:0] occ
);

  logic             v_s    [DEPTH];
  logic             r_s    [DEPTH];
  logic             down_s [DEPTH];
  logic             load_s [DEPTH];
  logic [WIDTH-1:0] d_s    [DEPTH];
  logic [WIDTH-1:0] din_s  [DEPTH];
  logic             in_fire_s;

  // The ready chain runs from the output back to stage 0; flush blocks intake.
  assign in_ready  = r_s[0] && !flush;
  assign in_fire_s = in_valid && in_ready;
  assign out_valid = v_s[DEPTH-1];
  assign out_data  = d_s[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == DEPTH - 1) begin : g_last
      assign down_s[g] = out_ready;
    end else begin : g_mid
      assign down_s[g] = r_s[g+1];
    end

    if (g == 0) begin : g_first
      assign load_s[g] = in_fire_s;
      assign din_s[g]  = in_data;
    end else begin : g_next
      // Stage g pulls its predecessor's beat whenever it has room for it.
      assign load_s[g] = v_s[g-1] && r_s[g] && !flush;
      assign din_s[g]  = d_s[g-1];
    end

    reg_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .load       (load_s[g]),
      .d_in       (din_s[g]),
      .down_ready (down_s[g]),
      .v          (v_s[g]),
      .d          (d_s[g]),
      .ready      (r_s[g])
    );
  end

`ifdef REG_PIPE_OCC_EN
  logic            out_fire_s;
  logic [OCCW-1:0] occ_r;

  // Beats shuffled between stages do not change the population of valid
  // flags, so tracking entries and exits keeps occ equal to popcount(v).
  assign out_fire_s = out_valid && out_ready && !flush;
  assign occ        = occ_r;

  // Occupancy register, updated on the same edge as the valid flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= {OCCW{1'b0}};
    end else if (flush) begin
      occ_r <= {OCCW{1'b0}};
    end else begin
      occ_r <= occ_r + OCCW'(in_fire_s) - OCCW'(out_fire_s);
    end
  end
`else
  assign occ = {OCCW{1'b0}};
`endif

endmodule : reg_pipe

// File: tb/tb_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_reg_pipe
// Self-checking bench for reg_pipe (WIDTH=8, DEPTH=4). A beat-position model
// (queue of beats, each with the stage index it occupies) predicts in_ready,
// out_valid, out_data and occ. occ is expected to be zero unless
// REG_PIPE_OCC_EN is defined.
// -----------------------------------------------------------------------------
module tb_reg_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCCW  = $clog2(DEPTH + 1);
`ifdef REG_PIPE_OCC_EN
  localparam bit OCC_ON = 1'b1;
`else
  localparam bit OCC_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCCW-1:0]  occ;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } beat_t;

  beat_t q[$];

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic exp_in_ready();
    return !flush && !(q.size() == DEPTH && !out_ready);
  endfunction

  function automatic logic exp_out_valid();
    return (q.size() > 0) && (q[0].pos == DEPTH - 1);
  endfunction

  function automatic logic [OCCW-1:0] exp_occ();
    return OCC_ON ? OCCW'(q.size()) : {OCCW{1'b0}};
  endfunction

  function automatic logic [OCCW-1:0] occ_of(input int n);
    return OCC_ON ? OCCW'(n) : {OCCW{1'b0}};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic  acc;
    int    lim;
    beat_t b;
    if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && exp_in_ready();
      if (exp_out_valid() && out_ready) void'(q.pop_front());
      lim = DEPTH - 1;
      for (int i = 0; i < q.size(); i++) begin
        b = q[i];
        b.pos = (b.pos + 1 < lim) ? b.pos + 1 : lim;
        q[i] = b;
        lim = b.pos - 1;
      end
      if (acc) begin
        b.data = in_data;
        b.pos  = 0;
        q.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_checks++; if (occ !== {OCCW{1'b0}}) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occ); end
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
    n_checks++; if (occ !== occ_of(1)) begin n_fail++; $display("FAIL single_occ_e0: got %0d expected %0d", occ, occ_of(1)); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (out_valid !== (k == 3)) begin n_fail++; $display("FAIL single_valid_e%0d: got %b expected %b", k, out_valid, (k == 3)); end
      n_checks++; if (occ !== occ_of(1)) begin n_fail++; $display("FAIL single_occ_e%0d: got %0d expected %0d", k, occ, occ_of(1)); end
    end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", out_data); end
    tick();
    n_checks++; if (out_valid !== 1'b0 || occ !== occ_of(0)) begin n_fail++; $display("FAIL single_gone: got valid=%b occ=%0d expected valid=0 occ=%0d", out_valid, occ, occ_of(0)); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] got[$];
    int               cyc[$];
    int               idx;
    logic             acc;
    out_ready = 1'b0; idx = 1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_data = WIDTH'(idx);
      #1;
      n_checks++; if (in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected %b", c, in_ready, exp_in_ready()); end
      acc = exp_in_ready();
      tick();
      if (acc) idx++;
    end
    n_checks++; if (idx != 5) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", idx - 1); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    n_checks++; if (occ !== occ_of(4)) begin n_fail++; $display("FAIL bp_full_occ: got %0d expected %0d", occ, occ_of(4)); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx <= 6); in_data = WIDTH'(idx);
      #1;
      acc = in_valid && exp_in_ready();
      if (out_valid && out_ready) begin got.push_back(out_data); cyc.push_back(c); end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    n_checks++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++; if (got[i] !== WIDTH'(i + 1) || cyc[i] != i) begin n_fail++; $display("FAIL bp_drain_%0d: got %h at cycle %0d expected %h at cycle %0d", i, got[i], cyc[i], WIDTH'(i + 1), i); end
    end
  endtask

  task automatic test_full_stream();
    out_ready = 1'b0;
    for (int c = 0; c < 8 && q.size() < DEPTH; c++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      tick();
    end
    n_checks++; if (occ !== occ_of(DEPTH) || in_ready !== 1'b0) begin n_fail++; $display("FAIL stream_fill: got occ=%0d in_ready=%b expected occ=%0d in_ready=0", occ, in_ready, occ_of(DEPTH)); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      #1;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_hs_c%0d: got in_ready=%b out_valid=%b expected 1 1", c, in_ready, out_valid); end
      n_checks++; if (out_data !== q[0].data) begin n_fail++; $display("FAIL stream_data_c%0d: got %h expected %h", c, out_data, q[0].data); end
      n_checks++; if (occ !== occ_of(DEPTH)) begin n_fail++; $display("FAIL stream_occ_c%0d: got %0d expected %0d", c, occ, occ_of(DEPTH)); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (occ !== occ_of(0) || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got occ=%0d out_valid=%b expected 0 0", occ, out_valid); end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak_c%0d: got out_valid=%b data=%h expected 0", c, out_valid, out_data); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = WIDTH'(8'h30 + c);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b1 || occ !== occ_of(3)) begin n_fail++; $display("FAIL arst_pre: got out_valid=%b occ=%0d expected 1 %0d", out_valid, occ, occ_of(3)); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || occ !== {OCCW{1'b0}} || out_data !== 8'h00) begin n_fail++; $display("FAIL arst_now: got out_valid=%b occ=%0d data=%h expected 0 0 00", out_valid, occ, out_data); end
    q.delete();
    #1 rst = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_resume_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (out_valid !== (k == 3)) begin n_fail++; $display("FAIL arst_resume_e%0d: got %b expected %b", k, out_valid, (k == 3)); end
    end
    n_checks++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL arst_resume_data: got %h expected 5a", out_data); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_data   = WIDTH'($urandom);
      #1;
      n_checks++; if (in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL rand_in_ready_c%0d: got %b expected %b", c, in_ready, exp_in_ready()); end
      n_checks++; if (out_valid !== exp_out_valid()) begin n_fail++; $display("FAIL rand_out_valid_c%0d: got %b expected %b", c, out_valid, exp_out_valid()); end
      if (exp_out_valid()) begin
        n_checks++; if (out_data !== q[0].data) begin n_fail++; $display("FAIL rand_out_data_c%0d: got %h expected %h", c, out_data, q[0].data); end
      end
      n_checks++; if (occ !== exp_occ()) begin n_fail++; $display("FAIL rand_occ_c%0d: got %0d expected %0d", c, occ, exp_occ()); end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_full_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_pipe

// File: doc/reg_pipe.md
# reg_pipe

Parametrised, handshaked register pipeline: WIDTH-bit data through DEPTH register stages, each with its own valid bit. Valid/ready flow control on both sides. Empty stages are filled while the output is stalled (bubble collapsing). Sync flush and an optional occupancy count. It replaces single-bit D flip-flop stages wherever the design needs multi-bit, back-pressured retiming between blocks.

## Interface
- WIDTH, 8: data width in bits, ≥1
- DEPTH, 4: number of register stages, ≥1
- OCCW, $clog2(DEPTH+1): occupancy count width (derived; not to be overridden)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous and active-low
- flush  in  1  synchronous clear of all stages, active-high
- in_valid  in  1  upstream beat present
- in_data  in  WIDTH  upstream data
- in_ready  out  1  pipeline accepts beat this cycle
- out_valid  out  1  stage DEPTH-1 holds a beat
- out_data  out  WIDTH  stage DEPTH-1 data
- out_ready  in  1  downstream accepts beat this cycle
- occ  out  OCCW  number of valid stages

## Operation
- Stage i holds v[i] (valid) and d[i] (data). Stage 0 is the input, stage DEPTH-1 is the output.
- Ready chain (combinational):
  - r[DEPTH-1] = !v[DEPTH-1] || out_ready
  - r[i] = !v[i] || r[i+1]
  - in_ready = r[0] && !flush
- Transfer rules:
  - In: when in_valid && in_ready, stage 0 loads in_data and v[0] is set.
  - Between stages: stage i+1 loads d[i] when r[i+1] && v[i]. v[i] clears if stage i is not reloaded in the same cycle.
  - Out: a beat leaves when out_valid && out_ready.
- Stage data changes only on a load. d of an invalid stage holds its last value, and that value is don't-care.
- Flush: on the next edge all v clear and data is untouched. A beat offered during flush is not accepted (in_ready=0). No output transfer counts during flush, even if out_ready=1.
- Output ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush or reset.
- occ = popcount(v), registered alongside v.
- Full: all v=1 and out_ready=0 gives in_ready=0.
- Full with out_ready=1: in_ready=1 and the whole pipe advances (100% throughput).
- Empty: out_valid=0, occ=0.

## Timing
- Reset (rst=0, asynchronous): all v=0, all d=0. This gives out_valid=0, out_data=0, occ=0, and in_ready=1 once flush=0.
- Reset mid-operation: all beats in flight are discarded immediately. The first edge after release may accept a beat.
- Latency into an empty pipe with out_ready held high: a beat accepted at edge n is presented at out_valid at edge n+DEPTH-1. Minimum DEPTH cycles from in_valid to output handshake.
- Throughput: one beat per cycle while out_ready=1.
- in_ready depends combinationally on out_ready. This path spans DEPTH stages and is the critical path.

## Configuration
- Macro `REG_PIPE_OCC_EN`.
- Defined: the occ counter is implemented as specified.
- Undefined: the occ port remains and is tied to 0, with no popcount logic.

## Structure
- Package reg_pipe_pkg holds:
  - localparam REG_PIPE_DEPTH_MAX = 64
  - function clog2_p1(n) for the OCCW computation
  - typedef pipe_stage_t = struct {valid, data} for benches
- One sub-module, reg_pipe_stage: a single WIDTH-bit stage with v, d, load, clear and the ready computation, instantiated DEPTH times by generate.
- reg_pipe top: ready chain, flush gating and occ logic.

## Test plan
- Reset state: rst=0, then release with flush=0 -> out_valid=0, out_data=0, occ=0, in_ready=1.
- Single beat, WIDTH=8, DEPTH=4, out_ready=1: in_data=8'hA5 accepted at edge 0 -> out_valid=1 with out_data=8'hA5 after edge 3, occ=1 during transit.
- Back-pressure fill: stream 8'h01..8'h06 with out_ready=0 -> 4 accepted, in_ready=0 with occ=4. Raising out_ready then drains 01,02,03,04 in order, one per cycle, then 05,06.
- Full streaming: pipe full, out_ready=1 and in_valid=1 for 10 cycles -> one beat in and one beat out every cycle, occ stays 4.
- Flush while full with in_valid=1 -> in_ready=0 that cycle, next edge occ=0 and out_valid=0. The offered beat never appears at the output.
- Async reset mid-stream: rst low between edges with occ=3 -> out_valid=0 and occ=0 immediately, before the next clk edge. Beats resume normally after release.
